// File: rtl/chasy_pkg.sv
// Shared types, field limits and the wrap-around field step for the time-setting sequencer.
package chasy_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        EDIT_HOUR = 3'd1,
        EDIT_MIN  = 3'd2,
        EDIT_SEC  = 3'd3,
        COMMIT    = 3'd4
    } setup_state_t;

    localparam logic [7:0] HOUR_MAX = 8'd23;
    localparam logic [7:0] MIN_MAX  = 8'd59;
    localparam logic [7:0] SEC_MAX  = 8'd59;

    localparam int HOUR_LSB = 16;
    localparam int MIN_LSB  = 8;
    localparam int SEC_LSB  = 0;

    // Out-of-range captures (corrupt live time) snap to 0 on inc and to max on dec.
    function automatic logic [7:0] field_step(input logic [7:0] value,
                                              input logic [7:0] max_val,
                                              input logic       up);
        logic [7:0] res;
        if (up) begin
            if (value >= max_val) begin
                res = 8'd0;
            end else begin
                res = value + 8'd1;
            end
        end else begin
            if ((value == 8'd0) || (value > max_val)) begin
                res = max_val;
            end else begin
                res = value - 8'd1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/chasy_tick_timer.sv
// Free-running cycle counter that flags the last cycle of each LIMIT-long period while enabled.
module chasy_tick_timer #(
    parameter int unsigned LIMIT = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic hit
);

    localparam int unsigned W    = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt_r;

    assign hit = en && !clr && (cnt_r == LAST);

    // Period counter: clear wins, wraps to zero on the last cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (en) begin
            if (cnt_r == LAST) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + W'(1);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/chasy_setup_ctrl.sv
// Front-panel time-setting sequencer: edits a shadow copy of the live time field by field
// and hands it to the clock core with a single load strobe.
module chasy_setup_ctrl
    import chasy_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 500000000,
    parameter int unsigned BLINK_CYC   = 12500000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        btn_mode,
    input  logic        btn_inc,
    input  logic        btn_dec,
    input  logic [23:0] time_in,
    output logic [23:0] setup_data,
    output logic        setup_imp,
    output logic        editing,
    output logic [23:0] disp_data,
    output logic [2:0]  blink_mask
);

    setup_state_t state_r;
    setup_state_t state_s;
    logic [23:0]  shadow_r;
    logic [23:0]  shadow_s;
    logic         phase_r;
    logic         phase_s;
    logic         editing_r;
    logic         setup_imp_r;
    logic [2:0]   blink_mask_r;
    logic [2:0]   blink_mask_s;
    logic [7:0]   field_s;
    logic [7:0]   field_max_s;
    logic [7:0]   stepped_s;
    logic         in_edit_s;
    logic         any_btn_s;
    logic         to_hit_s;
    logic         blink_hit_s;

    assign in_edit_s = (state_r inside {EDIT_HOUR, EDIT_MIN, EDIT_SEC});
    assign any_btn_s = btn_mode | btn_inc | btn_dec;

    chasy_tick_timer #(.LIMIT(TIMEOUT_CYC)) u_timeout (
        .clock (clock),
        .reset (reset),
        .clr   (!in_edit_s || any_btn_s),
        .en    (in_edit_s),
        .hit   (to_hit_s)
    );

    chasy_tick_timer #(.LIMIT(BLINK_CYC)) u_blink (
        .clock (clock),
        .reset (reset),
        .clr   (!in_edit_s || btn_mode),
        .en    (in_edit_s),
        .hit   (blink_hit_s)
    );

    // Select the byte lane and limit of the field currently being edited.
    always_comb begin
        case (state_r)
            EDIT_HOUR: begin
                field_s     = shadow_r[HOUR_LSB +: 8];
                field_max_s = HOUR_MAX;
            end
            EDIT_MIN: begin
                field_s     = shadow_r[MIN_LSB +: 8];
                field_max_s = MIN_MAX;
            end
            default: begin
                field_s     = shadow_r[SEC_LSB +: 8];
                field_max_s = SEC_MAX;
            end
        endcase
    end

    assign stepped_s = field_step(field_s, field_max_s, btn_inc);

    // Next state, shadow and blink phase; mode outranks inc/dec, and inc+dec cancel out.
    always_comb begin
        state_s  = state_r;
        shadow_s = shadow_r;
        phase_s  = phase_r;
        case (state_r)
            IDLE: begin
                if (btn_mode) begin
                    shadow_s = time_in;
                    state_s  = EDIT_HOUR;
                    phase_s  = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            EDIT_HOUR, EDIT_MIN, EDIT_SEC: begin
                if (btn_mode) begin
                    phase_s = 1'b1;
                    case (state_r)
                        EDIT_HOUR: state_s = EDIT_MIN;
                        EDIT_MIN:  state_s = EDIT_SEC;
                        default:   state_s = COMMIT;
                    endcase
                end else if (to_hit_s) begin
                    state_s = IDLE;
                end else begin
                    if (btn_inc != btn_dec) begin
                        case (state_r)
                            EDIT_HOUR: shadow_s[HOUR_LSB +: 8] = stepped_s;
                            EDIT_MIN:  shadow_s[MIN_LSB +: 8]  = stepped_s;
                            default:   shadow_s[SEC_LSB +: 8]  = stepped_s;
                        endcase
                    end else begin
                        shadow_s = shadow_r;
                    end
                    if (blink_hit_s) begin
                        phase_s = !phase_r;
                    end else begin
                        phase_s = phase_r;
                    end
                end
            end
            COMMIT: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Blink mask is computed from the next state so it lines up with the registered state.
    always_comb begin
        case (state_s)
            EDIT_HOUR: blink_mask_s = {phase_s, 2'b00};
            EDIT_MIN:  blink_mask_s = {1'b0, phase_s, 1'b0};
            EDIT_SEC:  blink_mask_s = {2'b00, phase_s};
            default:   blink_mask_s = 3'b000;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            shadow_r     <= 24'h000000;
            phase_r      <= 1'b1;
            editing_r    <= 1'b0;
            setup_imp_r  <= 1'b0;
            blink_mask_r <= 3'b000;
        end else begin
            state_r      <= state_s;
            shadow_r     <= shadow_s;
            phase_r      <= phase_s;
            editing_r    <= (state_s inside {EDIT_HOUR, EDIT_MIN, EDIT_SEC});
            setup_imp_r  <= (state_s == COMMIT);
            blink_mask_r <= blink_mask_s;
        end
    end

    assign setup_data = shadow_r;
    assign setup_imp  = setup_imp_r;
    assign editing    = editing_r;
    assign blink_mask = blink_mask_r;
    assign disp_data  = editing_r ? shadow_r : time_in;

endmodule
